// File: rtl/idex_hazard_register.sv
// ID/EX pipeline register with built-in load-use stall detection.
// Flushes on taken branches and counts stall cycles (saturating).
module idex_hazard_register #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [3:0]       id_funct4,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_Branch,
  input  logic             id_ALUSrc,
  input  logic [1:0]       id_ALUOp,
  input  logic             ex_flush,
  output logic             IDEX_valid,
  output logic [4:0]       IDEX_rs1,
  output logic [4:0]       IDEX_rs2,
  output logic [4:0]       IDEX_rd,
  output logic [XLEN-1:0]  IDEX_pc,
  output logic [XLEN-1:0]  IDEX_rs1_data,
  output logic [XLEN-1:0]  IDEX_rs2_data,
  output logic [XLEN-1:0]  IDEX_imm,
  output logic [3:0]       IDEX_funct4,
  output logic             IDEX_RegWrite,
  output logic             IDEX_MemtoReg,
  output logic             IDEX_MemRead,
  output logic             IDEX_MemWrite,
  output logic             IDEX_Branch,
  output logic             IDEX_ALUSrc,
  output logic [1:0]       IDEX_ALUOp,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_count
);

  logic lu;
  logic hazard;
  logic bubble;
  logic cv;

  assign lu = IDEX_valid & IDEX_MemRead
            & (IDEX_rd != 5'd0) & id_valid
            & ((IDEX_rd == id_rs1) | (IDEX_rd == id_rs2));

  // A flush discards the ID instruction, so it must not also stall the PC.
  assign hazard     = lu & ~ex_flush;
  assign pc_write   = ~hazard;
  assign ifid_write = ~hazard;

  assign bubble = ex_flush | hazard;
  assign cv     = id_valid;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      IDEX_valid    <= 1'b0;
      IDEX_rs1      <= '0;
      IDEX_rs2      <= '0;
      IDEX_rd       <= '0;
      IDEX_pc       <= '0;
      IDEX_rs1_data <= '0;
      IDEX_rs2_data <= '0;
      IDEX_imm      <= '0;
      IDEX_funct4   <= '0;
      IDEX_RegWrite <= 1'b0;
      IDEX_MemtoReg <= 1'b0;
      IDEX_MemRead  <= 1'b0;
      IDEX_MemWrite <= 1'b0;
      IDEX_Branch   <= 1'b0;
      IDEX_ALUSrc   <= 1'b0;
      IDEX_ALUOp    <= '0;
    end else begin
      IDEX_valid    <= id_valid;
      IDEX_rs1      <= id_rs1;
      IDEX_rs2      <= id_rs2;
      IDEX_rd       <= id_rd;
      IDEX_pc       <= id_pc;
      IDEX_rs1_data <= id_rs1_data;
      IDEX_rs2_data <= id_rs2_data;
      IDEX_imm      <= id_imm;
      IDEX_funct4   <= id_funct4;
      IDEX_RegWrite <= cv & id_RegWrite;
      IDEX_MemtoReg <= cv & id_MemtoReg;
      IDEX_MemRead  <= cv & id_MemRead;
      IDEX_MemWrite <= cv & id_MemWrite;
      IDEX_Branch   <= cv & id_Branch;
      IDEX_ALUSrc   <= cv & id_ALUSrc;
      IDEX_ALUOp    <= cv ? id_ALUOp : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (hazard && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

endmodule
